imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the decode stage. It accepts a bundle of `LANES` instructions per cycle and produces sign-extended `XLEN`-bit immediates plus a per-lane format code. It covers I/S/B/U/J formats, including AUIPC. Output is registered behind a valid/ready handshake with a two-entry skid buffer, so decode back-pressure never drops or reorders a bundle.

---
 rtl/imm_gen_pkg.sv | 49 ++++
 rtl/imm_lane_decode.sv | 53 +++++
 rtl/imm_gen_pipe.sv | 143 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined immediate generator: opcodes, format codes, per-lane storage entry.
// The target field exists only when IMM_GEN_PC_REL_EN is defined.
package imm_gen_pkg;

  localparam int MAX_XLEN = 64;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  // One lane of a stored bundle; imm is kept at full width and sliced to XLEN at the output.
  typedef struct packed {
    logic                valid;
    logic [MAX_XLEN-1:0] imm;
    imm_fmt_t            fmt;
`ifdef IMM_GEN_PC_REL_EN
    logic [MAX_XLEN-1:0] target;
`endif
  } lane_entry_t;

  function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(MAX_XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic fmt_is_pc_rel(input imm_fmt_t f, input logic is_auipc);
    return (f == FMT_B) || (f == FMT_J) || is_auipc;
  endfunction

endpackage

// File: rtl/imm_lane_decode.sv
// Combinational single-lane immediate decoder: 32-bit instruction in, sign-extended imm,
// format code and AUIPC flag out.
module imm_lane_decode
  import imm_gen_pkg::*;
(
  input  logic [31:0]         instr,
  output logic [MAX_XLEN-1:0] imm,
  output imm_fmt_t            fmt,
  output logic                is_auipc
);

  logic [31:0] imm32;

  always_comb begin
    imm32    = '0;
    fmt      = FMT_NONE;
    is_auipc = 1'b0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        // shift-immediates keep funct7 in the upper bits
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        fmt      = FMT_U;
        is_auipc = 1'b1;
        imm32    = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        fmt   = FMT_NONE;
        imm32 = '0;
      end
    endcase
    imm = sext32(imm32);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined multi-lane immediate generator with a two-entry skid buffer on the output handshake.
// Define IMM_GEN_PC_REL_EN to add in_pc / out_target and the per-lane PC-relative adders.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_valid,
  input  logic [LANES*32-1:0]   in_instr,
`ifdef IMM_GEN_PC_REL_EN
  input  logic [XLEN-1:0]       in_pc,
  output logic [LANES*XLEN-1:0] out_target,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_valid,
  output logic [LANES*XLEN-1:0] out_imm,
  output logic [LANES*3-1:0]    out_fmt
);

  skid_state_t state_reg, state_next;
  logic        in_ready_reg;
  logic        out_valid_reg;
  logic        acc, drn;
  logic        load_main, load_skid, pop_skid;

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign acc       = in_valid && in_ready_reg;
  assign drn       = out_valid_reg && out_ready;

  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    pop_skid   = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (acc) begin
          state_next = ST_ONE;
          load_main  = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && !drn) begin
          state_next = ST_TWO;
          load_skid  = 1'b1;
        end else if (acc && drn) begin
          load_main = 1'b1;
        end else if (drn) begin
          state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can happen
        if (drn) begin
          state_next = ST_ONE;
          pop_skid   = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    if (flush) begin
      state_next = ST_EMPTY;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      pop_skid   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_ready_reg  <= (state_next != ST_TWO);
      out_valid_reg <= (state_next != ST_EMPTY);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [MAX_XLEN-1:0] dec_imm;
    imm_fmt_t            dec_fmt;
    logic                dec_auipc;
    lane_entry_t         lane_new;
    lane_entry_t         main_reg;
    lane_entry_t         skid_reg;

    imm_lane_decode u_dec (
      .instr    (in_instr[32*gi +: 32]),
      .imm      (dec_imm),
      .fmt      (dec_fmt),
      .is_auipc (dec_auipc)
    );

    always_comb begin
      lane_new       = '0;
      lane_new.valid = in_lane_valid[gi];
      if (in_lane_valid[gi]) begin
        lane_new.imm = dec_imm;
        lane_new.fmt = dec_fmt;
`ifdef IMM_GEN_PC_REL_EN
        // lane PC is lane 0's PC plus 4 per lane, all wrapping at XLEN
        if (fmt_is_pc_rel(dec_fmt, dec_auipc)) begin
          lane_new.target[XLEN-1:0] = in_pc + XLEN'(4 * gi) + dec_imm[XLEN-1:0];
        end
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        main_reg <= '0;
        skid_reg <= '0;
      end else begin
        if (load_main) begin
          main_reg <= lane_new;
        end else if (pop_skid) begin
          main_reg <= skid_reg;
        end
        if (load_skid) begin
          skid_reg <= lane_new;
        end
      end
    end

    assign out_lane_valid[gi]         = main_reg.valid;
    assign out_imm[gi*XLEN +: XLEN]   = main_reg.imm[XLEN-1:0];
    assign out_fmt[gi*3 +: 3]         = main_reg.fmt;
`ifdef IMM_GEN_PC_REL_EN
    assign out_target[gi*XLEN +: XLEN] = main_reg.target[XLEN-1:0];
`endif
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: vector table, hand-written handshake sequences and a
// randomized run against a queue-based reference model.
module tb_imm_gen_pipe;

  localparam int LANES = 2;
  localparam int XLEN  = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_lane_valid;
  logic [63:0]  in_instr;
  logic [63:0]  in_pc;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_lane_valid;
  logic [127:0] out_imm;
  logic [5:0]   out_fmt;
  logic [127:0] out_target;

  logic         in_valid32;
  logic         in_ready32;
  logic         out_valid32;
  logic [0:0]   out_lane_valid32;
  logic [31:0]  out_imm32;
  logic [2:0]   out_fmt32;
`ifdef IMM_GEN_PC_REL_EN
  logic [31:0]  out_target32;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(.LANES(LANES), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_valid  (in_lane_valid),
    .in_instr       (in_instr),
`ifdef IMM_GEN_PC_REL_EN
    .in_pc          (in_pc),
    .out_target     (out_target),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_imm        (out_imm),
    .out_fmt        (out_fmt)
  );

  imm_gen_pipe #(.LANES(1), .XLEN(32)) dut32 (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid32),
    .in_ready       (in_ready32),
    .in_lane_valid  (in_lane_valid[0:0]),
    .in_instr       (in_instr[31:0]),
`ifdef IMM_GEN_PC_REL_EN
    .in_pc          (in_pc[31:0]),
    .out_target     (out_target32),
`endif
    .out_valid      (out_valid32),
    .out_ready      (1'b1),
    .out_lane_valid (out_lane_valid32),
    .out_imm        (out_imm32),
    .out_fmt        (out_fmt32)
  );

`ifndef IMM_GEN_PC_REL_EN
  assign out_target = '0;
`endif

  typedef struct packed {
    logic [1:0]   lv;
    logic [127:0] imm;
    logic [5:0]   fmt;
    logic [127:0] tgt;
  } exp_t;

  typedef struct {
    logic [1:0]  lv;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [63:0] pc;
    logic [63:0] e_imm0;
    logic [2:0]  e_fmt0;
    logic [63:0] e_imm1;
    logic [2:0]  e_fmt1;
    logic [63:0] e_tgt0;
    logic [63:0] e_tgt1;
    logic [31:0] e_imm32;
    logic [2:0]  e_fmt32;
  } vec_t;

  exp_t mq[$];
  vec_t vt[5];
  int   total = 0;
  int   bad   = 0;
  int   nxfer = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp_v);
    end
  endtask

  // Immediates from the ISA field layout, built with signed 64-bit arithmetic.
  function automatic void ref_dec(input logic [31:0] ins, output logic [63:0] imm,
                                  output logic [2:0] fmt, output bit rel);
    longint sx;
    sx  = longint'(signed'(ins));
    imm = '0;
    fmt = 3'd0;
    rel = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin
        fmt = 3'd1;
        imm = sx >>> 20;
      end
      7'h23: begin
        fmt = 3'd2;
        imm = (sx >>> 25) * 32 + longint'(ins[11:7]);
      end
      7'h63: begin
        fmt = 3'd3;
        rel = 1'b1;
        imm = (sx >>> 31) * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
              + longint'(ins[11:8]) * 2;
      end
      7'h37: begin
        fmt = 3'd4;
        imm = (sx >>> 12) * 4096;
      end
      7'h17: begin
        fmt = 3'd4;
        rel = 1'b1;
        imm = (sx >>> 12) * 4096;
      end
      7'h6F: begin
        fmt = 3'd5;
        rel = 1'b1;
        imm = (sx >>> 31) * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
              + longint'(ins[30:21]) * 2;
      end
      default: ;
    endcase
  endfunction

  function automatic exp_t make_exp();
    exp_t        e;
    logic [63:0] im;
    logic [2:0]  f;
    bit          rel;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      e.lv[i] = in_lane_valid[i];
      if (in_lane_valid[i]) begin
        ref_dec(in_instr[32*i +: 32], im, f, rel);
        e.imm[64*i +: 64] = im;
        e.fmt[3*i +: 3]   = f;
`ifdef IMM_GEN_PC_REL_EN
        if (rel) e.tgt[64*i +: 64] = in_pc + 64'(4 * i) + im;
`endif
      end
    end
    return e;
  endfunction

  task automatic check_state();
    exp_t e;
    chk("out_valid", {127'd0, out_valid}, {127'd0, mq.size() != 0});
    chk("in_ready", {127'd0, in_ready}, {127'd0, mq.size() != 2});
    if (mq.size() != 0) begin
      e = mq[0];
      chk("out_lane_valid", {126'd0, out_lane_valid}, {126'd0, e.lv});
      chk("out_imm", out_imm, e.imm);
      chk("out_fmt", {122'd0, out_fmt}, {122'd0, e.fmt});
`ifdef IMM_GEN_PC_REL_EN
      chk("out_target", out_target, e.tgt);
`endif
    end
  endtask

  // Advance the model by the handshake about to happen, clock once, then check.
  task automatic tick();
    bit drn, acc;
    drn = (mq.size() != 0) && out_ready;
    acc = in_valid && (mq.size() != 2);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (drn) begin
        nxfer++;
        $display("xfer %0d lv=%b imm=%h fmt=%h pc=%h", nxfer, mq[0].lv, mq[0].imm, mq[0].fmt, in_pc);
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(make_exp());
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    logic [31:0] r0, r1;
    logic [6:0]  ops[10];

    vt[0] = '{2'b11, 32'hFFF00093, 32'hFE112E23, 64'h1000,
              64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2,
              64'h0, 64'h0, 32'hFFFF_FFFF, 3'd1};
    vt[1] = '{2'b11, 32'hFE000EE3, 32'h0080006F, 64'h1000,
              64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 64'h8, 3'd5,
              64'h0FFC, 64'h100C, 32'hFFFF_FFFC, 3'd3};
    vt[2] = '{2'b11, 32'h80000037, 32'h00000013, 64'h2000,
              64'hFFFF_FFFF_8000_0000, 3'd4, 64'h0, 3'd1,
              64'h0, 64'h0, 32'h8000_0000, 3'd4};
    vt[3] = '{2'b01, 32'h0000000B, 32'h0080006F, 64'h3000,
              64'h0, 3'd0, 64'h0, 3'd0,
              64'h0, 64'h0, 32'h0, 3'd0};
    vt[4] = '{2'b11, 32'h00001017, 32'hFFC08067, 64'hFFFF_FFFF_FFFF_FFF0,
              64'h1000, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1,
              64'h0FF0, 64'h0, 32'h1000, 3'd4};
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h0B, 7'h33};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid32 = 1'b0; out_ready = 1'b0;
    in_lane_valid = 2'b11; in_instr = '0; in_pc = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_imm", out_imm, 128'd0);
    chk("rst_fmt", {122'd0, out_fmt}, 128'd0);
    chk("rst_lane_valid", {126'd0, out_lane_valid}, 128'd0);
    chk("rst_target", out_target, 128'd0);

    // vector table, streaming with out_ready held high
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_valid32 = 1'b1;
      in_lane_valid = vt[k].lv;
      in_instr = {vt[k].i1, vt[k].i0};
      in_pc = vt[k].pc;
      tick();
      chk($sformatf("tbl%0d_imm0", k), {64'd0, out_imm[63:0]}, {64'd0, vt[k].e_imm0});
      chk($sformatf("tbl%0d_fmt0", k), {125'd0, out_fmt[2:0]}, {125'd0, vt[k].e_fmt0});
      chk($sformatf("tbl%0d_imm1", k), {64'd0, out_imm[127:64]}, {64'd0, vt[k].e_imm1});
      chk($sformatf("tbl%0d_fmt1", k), {125'd0, out_fmt[5:3]}, {125'd0, vt[k].e_fmt1});
`ifdef IMM_GEN_PC_REL_EN
      chk($sformatf("tbl%0d_tgt0", k), {64'd0, out_target[63:0]}, {64'd0, vt[k].e_tgt0});
      chk($sformatf("tbl%0d_tgt1", k), {64'd0, out_target[127:64]}, {64'd0, vt[k].e_tgt1});
`endif
      chk($sformatf("tbl%0d_x32_valid", k), {127'd0, out_valid32}, 128'd1);
      chk($sformatf("tbl%0d_x32_imm", k), {96'd0, out_imm32}, {96'd0, vt[k].e_imm32});
      chk($sformatf("tbl%0d_x32_fmt", k), {125'd0, out_fmt32}, {125'd0, vt[k].e_fmt32});
    end
    in_valid = 1'b0; in_valid32 = 1'b0;
    tick();
    tick();

    // back-pressure: A and B fill main and skid, then drain in order
    in_lane_valid = 2'b11; in_pc = 64'h4000;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = {32'h0080006F, 32'hFFF00093};
    tick();
    chk("bp_ready_after_a", {127'd0, in_ready}, 128'd1);
    in_instr = {32'h00000013, 32'h80000037};
    tick();
    chk("bp_ready_after_b", {127'd0, in_ready}, 128'd0);
    in_valid = 1'b0;
    tick();
    chk("bp_hold_a", {64'd0, out_imm[63:0]}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    out_ready = 1'b1;
    tick();
    chk("bp_b_next", {64'd0, out_imm[63:0]}, {64'd0, 64'hFFFF_FFFF_8000_0000});
    chk("bp_ready_back", {127'd0, in_ready}, 128'd1);
    tick();
    chk("bp_empty", {127'd0, out_valid}, 128'd0);

    // flush in TWO with a concurrent bundle: nothing may come out afterwards
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = {32'hFE112E23, 32'hFFF00093};
    tick();
    in_instr = {32'h0080006F, 32'hFE000EE3};
    tick();
    in_instr = {32'h00001017, 32'h80000037};
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_in_ready", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_stays_empty", {127'd0, out_valid}, 128'd0);
    end

    // reset mid-operation discards the held bundle
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_mid_imm", out_imm, 128'd0);
    chk("rst_mid_fmt", {122'd0, out_fmt}, 128'd0);

    // randomized traffic against the queue model
    for (int c = 0; c < 600; c++) begin
      r0 = $urandom();
      r1 = $urandom();
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 40) == 0);
      in_lane_valid = 2'($urandom_range(0, 3));
      in_instr      = {r1[31:7], ops[$urandom_range(0, 9)], r0[31:7], ops[$urandom_range(0, 9)]};
      in_pc         = {$urandom(), $urandom()};
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
